// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch sequencer and the PC unit it
// commands: PC opcodes, FSM state encoding and the HALT opcode value.
package fetch_ctrl_pkg;

  // PC unit commands. The PC unit applies one of these on the falling edge
  // that follows a change of the opcode.
  localparam logic [1:0] PC_HOLD = 2'b00;
  localparam logic [1:0] PC_INC  = 2'b01;
  localparam logic [1:0] PC_LOAD = 2'b10;
  localparam logic [1:0] PC_CLR  = 2'b11;

  // Top nibble of an instruction word that stops fetching.
  localparam logic [3:0] HALT_OP = 4'hF;

  // Fetch sequencer states.
  //   S_CLR  : one cycle, tells the PC unit to clear to 0
  //   S_REQ  : issue a memory read at the current PC and wait for the ack
  //   S_OUT  : present the fetched word to decode until it is taken
  //   S_ADV  : one cycle, tells the PC unit to increment or load
  //   S_HALT : idle after a HALT instruction until a branch arrives
  typedef enum logic [2:0] {
    S_CLR  = 3'd0,
    S_REQ  = 3'd1,
    S_OUT  = 3'd2,
    S_ADV  = 3'd3,
    S_HALT = 3'd4
  } state_t;

  // True when the opcode field of an instruction matches the halt opcode.
  function automatic logic is_halt_op(input logic [3:0] op_field,
                                      input logic [3:0] halt_op);
    return op_field == halt_op;
  endfunction

endpackage

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer. Drives the PC unit, reads instruction memory
// over a req/ack handshake and hands words to decode over valid/ready.
//
// Handshakes:
//   memory : O_mem_req rises with O_mem_addr and both stay stable until a
//            rising edge samples I_mem_ack=1; I_mem_data is taken in that
//            same cycle and O_mem_req drops on that edge. Ack is ignored
//            while O_mem_req=0.
//   decode : O_instr_valid rises with O_instr and both stay stable until a
//            rising edge samples I_instr_ready=1 (the transfer edge); valid
//            drops on that edge. Ready may be high before valid.
//
// A branch pulse may arrive in any state. It marks a redirect as pending
// with the latest target; the redirect is applied at the next S_ADV as a
// PC load. A word whose memory ack lands while a redirect is pending is
// discarded, since it belongs to the old instruction stream.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int         ADDR_W  = 16,
  parameter int         DATA_W  = 16,
  parameter logic [3:0] HALT_OP = fetch_ctrl_pkg::HALT_OP
) (
  input  logic              I_clk,
  input  logic              I_rst,
  // PC unit
  input  logic [ADDR_W-1:0] I_pc,
  output logic [1:0]        O_pc_opcode,
  output logic [ADDR_W-1:0] O_pc_next,
  // Instruction memory
  output logic              O_mem_req,
  output logic [ADDR_W-1:0] O_mem_addr,
  input  logic              I_mem_ack,
  input  logic [DATA_W-1:0] I_mem_data,
  // Decode
  output logic [DATA_W-1:0] O_instr,
  output logic              O_instr_valid,
  input  logic              I_instr_ready,
  // Redirect
  input  logic              I_branch_en,
  input  logic [ADDR_W-1:0] I_branch_target,
  // Status
  output logic              O_halted,
  output logic [15:0]       O_fetch_count,
  output state_t            O_dbg_state
);

  // ---------------------------------------------------------------------
  // State and branch bookkeeping
  // ---------------------------------------------------------------------
  state_t            state;
  state_t            state_d;

  logic              br_pending;
  logic [ADDR_W-1:0] br_target;

  // A pulse in the current cycle counts as pending immediately, and its
  // target takes precedence over an older latched one (latest wins).
  logic              br_eff;
  logic [ADDR_W-1:0] br_target_eff;

  // Handshake events seen at the coming rising edge.
  logic              mem_done;
  logic              handoff;
  logic              halt_hit;

  assign br_eff        = br_pending | I_branch_en;
  assign br_target_eff = I_branch_en ? I_branch_target : br_target;

  assign mem_done = (state == S_REQ) && O_mem_req && I_mem_ack;
  assign handoff  = (state == S_OUT) && I_instr_ready;
  assign halt_hit = is_halt_op(O_instr[DATA_W-1 -: 4], HALT_OP);

  assign O_dbg_state = state;

  // ---------------------------------------------------------------------
  // Next values of the registered outputs
  // ---------------------------------------------------------------------
  logic [1:0]        pc_opcode_d;
  logic [ADDR_W-1:0] pc_next_d;
  logic              mem_req_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [DATA_W-1:0] instr_d;
  logic              instr_valid_d;
  logic              halted_d;
  logic [15:0]       fetch_count_d;

  // State register: every state change happens here.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      state <= S_CLR;
    end else begin
      state <= state_d;
    end
  end

  // Next-state selection from the current state and handshake events.
  always_comb begin
    state_d = state;
    case (state)
      S_CLR: begin
        state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_done) begin
          state_d = br_eff ? S_ADV : S_OUT;
        end
      end
      S_OUT: begin
        if (handoff) begin
          state_d = (halt_hit && !br_eff) ? S_HALT : S_ADV;
        end
      end
      S_ADV: begin
        state_d = S_REQ;
      end
      S_HALT: begin
        if (I_branch_en) begin
          state_d = S_ADV;
        end
      end
      default: begin
        state_d = S_CLR;
      end
    endcase
  end

  // Output decode: computes what each registered output holds next cycle.
  always_comb begin
    // The PC opcode is a one-cycle pulse; everything else holds by default.
    pc_opcode_d   = PC_HOLD;
    pc_next_d     = O_pc_next;
    mem_req_d     = O_mem_req;
    mem_addr_d    = O_mem_addr;
    instr_d       = O_instr;
    instr_valid_d = O_instr_valid;
    halted_d      = O_halted;
    fetch_count_d = O_fetch_count;

    case (state)
      S_CLR: begin
        pc_opcode_d = PC_CLR;
      end
      S_REQ: begin
        if (!O_mem_req) begin
          // First cycle in S_REQ: the PC unit has already applied the
          // previous opcode on the falling edge, so I_pc is current.
          mem_req_d  = 1'b1;
          mem_addr_d = I_pc;
        end else if (I_mem_ack) begin
          mem_req_d = 1'b0;
          if (!br_eff) begin
            instr_d       = I_mem_data;
            instr_valid_d = 1'b1;
          end
        end
      end
      S_OUT: begin
        if (I_instr_ready) begin
          instr_valid_d = 1'b0;
          fetch_count_d = O_fetch_count + 16'd1;
          if (halt_hit && !br_eff) begin
            halted_d = 1'b1;
          end
        end
      end
      S_ADV: begin
        if (br_eff) begin
          pc_opcode_d = PC_LOAD;
          pc_next_d   = br_target_eff;
        end else begin
          pc_opcode_d = PC_INC;
        end
      end
      S_HALT: begin
        if (I_branch_en) begin
          halted_d = 1'b0;
        end
      end
      default: begin
        pc_opcode_d = PC_HOLD;
      end
    endcase
  end

  // Output registers: all outputs change only on the rising edge.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      O_pc_opcode   <= PC_HOLD;
      O_pc_next     <= '0;
      O_mem_req     <= 1'b0;
      O_mem_addr    <= '0;
      O_instr       <= '0;
      O_instr_valid <= 1'b0;
      O_halted      <= 1'b0;
      O_fetch_count <= '0;
    end else begin
      O_pc_opcode   <= pc_opcode_d;
      O_pc_next     <= pc_next_d;
      O_mem_req     <= mem_req_d;
      O_mem_addr    <= mem_addr_d;
      O_instr       <= instr_d;
      O_instr_valid <= instr_valid_d;
      O_halted      <= halted_d;
      O_fetch_count <= fetch_count_d;
    end
  end

  // Redirect capture: latch every pulse, consume the pending flag in S_ADV.
  // A pulse landing on the S_ADV edge itself is used there, so it must not
  // leave the flag set behind it.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      br_pending <= 1'b0;
      br_target  <= '0;
    end else begin
      if (I_branch_en) begin
        br_target <= I_branch_target;
      end
      if (state == S_ADV) begin
        br_pending <= 1'b0;
      end else if (I_branch_en) begin
        br_pending <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: PC unit and memory models, directed scenarios and a
// randomized phase, with a scoreboard-based transaction model.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  // ---------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] pc = 16'hDEAD;
  logic [1:0]  pc_opcode;
  logic [15:0] pc_next;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_data = 16'h0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_en = 1'b0;
  logic [15:0] branch_target = 16'h0;
  logic        halted;
  logic [15:0] fetch_count;
  state_t      dbg_state;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .I_clk           (clk),
    .I_rst           (rst),
    .I_pc            (pc),
    .O_pc_opcode     (pc_opcode),
    .O_pc_next       (pc_next),
    .O_mem_req       (mem_req),
    .O_mem_addr      (mem_addr),
    .I_mem_ack       (mem_ack),
    .I_mem_data      (mem_data),
    .O_instr         (instr),
    .O_instr_valid   (instr_valid),
    .I_instr_ready   (instr_ready),
    .I_branch_en     (branch_en),
    .I_branch_target (branch_target),
    .O_halted        (halted),
    .O_fetch_count   (fetch_count),
    .O_dbg_state     (dbg_state)
  );

  // ---------------------------------------------------------------------
  // Scoreboard state
  // ---------------------------------------------------------------------
  int          checks = 0;
  int          failures = 0;
  logic [15:0] exp_q[$];
  int          hand_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    failures++;
    $display("FAIL timeout_%s actual=no_event required=event time=%0t", name, $time);
  endtask

  // ---------------------------------------------------------------------
  // Environment models: PC unit and instruction memory
  // ---------------------------------------------------------------------
  int unsigned mem_lat = 0;
  bit          mem_rand = 1'b0;
  logic [15:0] halt_addr = 16'hFFFF;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a == halt_addr) ? 16'hF000 : a + 16'h1000;
  endfunction

  // PC unit: applies the opcode on the falling edge.
  initial begin : pc_unit
    forever begin
      @(negedge clk);
      case (pc_opcode)
        PC_INC:  pc = pc + 16'd1;
        PC_LOAD: pc = pc_next;
        PC_CLR:  pc = 16'h0;
        default: pc = pc;
      endcase
    end
  end

  // Memory: acks after a chosen number of idle cycles, junk data otherwise.
  initial begin : mem_model
    int wait_left;
    bit busy;
    busy = 1'b0;
    wait_left = 0;
    forever begin
      @(posedge clk);
      #2;
      if (mem_ack) begin
        mem_ack = 1'b0;
        busy = 1'b0;
        mem_data = 16'($urandom);
      end else if (!mem_req) begin
        busy = 1'b0;
        mem_data = 16'($urandom);
      end else begin
        if (!busy) begin
          busy = 1'b1;
          wait_left = mem_rand ? int'($urandom_range(0, 4)) : int'(mem_lat);
        end
        if (wait_left == 0) begin
          mem_ack = 1'b1;
          mem_data = mem_word(mem_addr);
        end else begin
          wait_left--;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Monitor / reference model. At each falling edge the registered outputs
  // reflect the last rising edge and the inputs describe the next one.
  // Transaction rules: after reset the PC clears and fetch starts at 0;
  // each fetched word is handed off unless a redirect arrived during its
  // fetch; every advance goes to PC+1, or to the latest redirect target
  // seen since the previous advance; a HALT word stops fetch until a
  // redirect.
  // ---------------------------------------------------------------------
  initial begin : monitor
    bit          m_pend, m_halted, m_expect_clr, m_adv_ok, m_adv_since_req;
    bit          prev_req, prev_held, prev_op_nz, check_zero, pulse;
    logic [15:0] m_tgt, m_addr, m_count, prev_addr, prev_instr, exp_i;
    int          post_rst;
    m_pend = 0; m_halted = 0; m_expect_clr = 0; m_adv_ok = 0; m_adv_since_req = 0;
    prev_req = 0; prev_held = 0; prev_op_nz = 0; check_zero = 0; post_rst = 0;
    m_tgt = 0; m_addr = 0; m_count = 0; prev_addr = 0; prev_instr = 0;
    forever begin
      @(negedge clk);
      if (check_zero) begin
        check("rst_pc_opcode", pc_opcode, 0);
        check("rst_pc_next", pc_next, 0);
        check("rst_mem_req", mem_req, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_instr", instr, 0);
        check("rst_instr_valid", instr_valid, 0);
        check("rst_halted", halted, 0);
        check("rst_fetch_count", fetch_count, 0);
        check_zero = 0;
      end
      if (rst) begin
        m_pend = 0; m_halted = 0; m_count = 0; m_expect_clr = 1;
        m_adv_ok = 0; m_adv_since_req = 0;
        prev_req = 0; prev_held = 0; prev_op_nz = 0;
        exp_q.delete();
        check_zero = 1;
        post_rst = 0;
      end else begin
        post_rst++;
        if (post_rst == 2) check("clr_after_reset", pc_opcode, PC_CLR);
        // PC actions taken at the last rising edge.
        if (pc_opcode != PC_HOLD) check("opcode_one_cycle", prev_op_nz, 0);
        if (pc_opcode == PC_CLR) begin
          check("pc_opcode_clr", pc_opcode, m_expect_clr ? PC_CLR : PC_HOLD);
          m_expect_clr = 0;
          m_addr = 16'h0;
          m_adv_since_req = 1;
        end else if (pc_opcode != PC_HOLD) begin
          check("pc_opcode_adv", pc_opcode,
                (m_adv_ok && !m_halted) ? (m_pend ? PC_LOAD : PC_INC) : PC_HOLD);
          if (m_pend) check("pc_next", pc_next, m_tgt);
          m_addr = m_pend ? m_tgt : m_addr + 16'd1;
          m_pend = 0;
          m_adv_ok = 0;
          m_adv_since_req = 1;
        end
        // Memory request side.
        if (mem_req && !prev_req) begin
          check("req_allowed", mem_req, m_adv_since_req && !m_halted);
          check("mem_addr", mem_addr, m_addr);
          check("valid_during_req", instr_valid, 0);
          m_adv_since_req = 0;
        end else if (mem_req) begin
          check("mem_addr_stable", mem_addr, prev_addr);
        end
        // Decode side hold while not accepted.
        if (prev_held) begin
          check("valid_hold", instr_valid, 1);
          check("instr_hold", instr, prev_instr);
        end
        check("halted", halted, m_halted);
        check("fetch_count", fetch_count, m_count);
        // Events at the coming rising edge.
        pulse = branch_en;
        if (mem_req && mem_ack) begin
          if (m_pend || pulse) m_adv_ok = 1;
          else exp_q.push_back(mem_word(m_addr));
        end
        if (instr_valid && instr_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_instr", instr_valid, 0);
          end else begin
            exp_i = exp_q.pop_front();
            check("instr", instr, exp_i);
            m_count = m_count + 16'd1;
            hand_cnt++;
            if (exp_i[15:12] == HALT_OP && !(m_pend || pulse)) m_halted = 1;
            else m_adv_ok = 1;
          end
        end else if (m_halted && pulse) begin
          m_halted = 0;
          m_adv_ok = 1;
        end
        if (pulse) begin
          m_pend = 1;
          m_tgt = branch_target;
        end
        prev_req = mem_req;
        prev_addr = mem_addr;
        prev_held = instr_valid && !instr_ready;
        prev_instr = instr;
        prev_op_nz = (pc_opcode != PC_HOLD);
      end
    end
  end

  // ---------------------------------------------------------------------
  // Driver tasks (inputs change 1 time unit after the rising edge)
  // ---------------------------------------------------------------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    tick(n);
    rst = 1'b0;
  endtask

  task automatic pulse_branch(input logic [15:0] t);
    branch_en = 1'b1;
    branch_target = t;
    tick(1);
    branch_en = 1'b0;
  endtask

  task automatic wait_req(input logic [15:0] a, input int budget, input string name);
    int n;
    n = 0;
    while (!(mem_req && mem_addr == a) && n < budget) begin
      tick(1);
      n++;
    end
    if (!(mem_req && mem_addr == a)) timeout(name);
  endtask

  task automatic wait_any_req(input int budget, input string name);
    int n;
    n = 0;
    while (!mem_req && n < budget) begin
      tick(1);
      n++;
    end
    if (!mem_req) timeout(name);
  endtask

  task automatic wait_valid(input int budget, input string name);
    int n;
    n = 0;
    while (!instr_valid && n < budget) begin
      tick(1);
      n++;
    end
    if (!instr_valid) timeout(name);
  endtask

  task automatic wait_halted(input int budget, input string name);
    int n;
    n = 0;
    while (!halted && n < budget) begin
      tick(1);
      n++;
    end
    if (!halted) timeout(name);
  endtask

  task automatic report();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
  endtask

  // Watchdog in case a directed step never completes.
  initial begin : watchdog
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog actual=running required=finished time=%0t", $time);
    failures++;
    report();
    $finish;
  end

  // ---------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------
  initial begin : stimulus
    int h0;
    // Straight-line fetch with ready stalled at the word from addr 2.
    do_reset(3);
    instr_ready = 1'b1;
    wait_req(16'h0002, 40, "req_addr2");
    instr_ready = 1'b0;
    wait_valid(40, "valid_addr2");
    check("stall_instr", instr, 16'h1002);
    tick(5);
    instr_ready = 1'b1;
    wait_req(16'h0004, 40, "req_addr4");
    check("fetch_count_after_4", fetch_count, 16'd4);
    mem_lat = 5;

    // Redirect while the request for addr 5 waits on its ack.
    wait_req(16'h0005, 60, "req_addr5");
    tick(2);
    pulse_branch(16'h0040);
    mem_lat = 0;
    wait_req(16'h0040, 60, "req_branch_0040");
    tick(10);

    // HALT word at addr 7, then resume with a redirect.
    halt_addr = 16'h0007;
    do_reset(3);
    wait_halted(200, "halt_addr7");
    tick(20);
    check("halted_hold", halted, 1);
    check("no_req_halted", mem_req, 0);
    pulse_branch(16'h0010);
    wait_req(16'h0010, 40, "req_resume_0010");
    halt_addr = 16'hFFFF;
    tick(12);

    // Reset in the middle of an outstanding request.
    mem_lat = 20;
    wait_any_req(40, "req_before_reset");
    tick(2);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check("req_drop_on_reset", mem_req, 0);
    mem_lat = 0;
    wait_req(16'h0000, 40, "req_after_reset");
    tick(6);

    // Redirect coincident with a handoff, then overwritten before S_ADV.
    instr_ready = 1'b0;
    wait_valid(40, "valid_coincident");
    instr_ready = 1'b1;
    branch_en = 1'b1;
    branch_target = 16'h0030;
    tick(1);
    branch_target = 16'h0080;
    tick(1);
    branch_en = 1'b0;
    wait_req(16'h0080, 40, "req_branch_0080");
    tick(10);

    // Randomized traffic with halts and redirects.
    halt_addr = 16'h0023;
    mem_rand = 1'b1;
    h0 = hand_cnt;
    for (int i = 0; i < 3000; i++) begin
      instr_ready = ($urandom_range(0, 9) < 7);
      branch_en = ($urandom_range(0, 19) == 0);
      branch_target = 16'($urandom_range(0, 255));
      tick(1);
    end
    branch_en = 1'b0;
    instr_ready = 1'b1;
    mem_rand = 1'b0;
    tick(20);
    check("random_progress", (hand_cnt - h0) > 100, 1);

    report();
    $finish;
  end

endmodule
